// File: rtl/pixel_sink_pkg.sv
// Shared constants and state encoding for the pixel sink framebuffer writer.
package pixel_sink_pkg;

    localparam int unsigned DEF_WIDTH_X    = 4;
    localparam int unsigned DEF_WIDTH_Y    = 3;
    localparam int unsigned DEF_RES_X      = 10;
    localparam int unsigned DEF_RES_Y      = 6;
    localparam int unsigned DEF_COLOR_W    = 3;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_ADDR_W     = 6;
    localparam int unsigned CLEAR_COLOR    = 0;

    typedef enum logic [1:0] {
        StStream = 2'd0,
        StDrain  = 2'd1,
        StClear  = 2'd2
    } state_e;

endpackage

// File: rtl/pixel_sink_if.sv
// Plotter-side pixel stream, clear control and framebuffer write port of the pixel sink.
interface pixel_sink_if
    import pixel_sink_pkg::*;
#(
    parameter int unsigned WIDTH_X = DEF_WIDTH_X,
    parameter int unsigned WIDTH_Y = DEF_WIDTH_Y,
    parameter int unsigned COLOR_W = DEF_COLOR_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) ();

    logic               plot;
    logic [WIDTH_X-1:0] x;
    logic [WIDTH_Y-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               ready;
    logic               clear;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_ready;
    logic               frame_done;
    logic               clear_done;
    logic [7:0]         clip_count;

    modport master (
        output plot, x, y, color, clear, mem_ready,
        input  ready, mem_we, mem_addr, mem_data, frame_done, clear_done, clip_count
    );

    modport slave (
        input  plot, x, y, color, clear, mem_ready,
        output ready, mem_we, mem_addr, mem_data, frame_done, clear_done, clip_count
    );

endinterface

// File: rtl/pixel_fifo.sv
// Power-of-two depth FIFO holding packed {x, y, color} pixel words.
module pixel_fifo #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                       (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/pixel_sink.sv
// Buffers plotted pixels, clips off-screen ones and streams them into a framebuffer;
// also performs full-screen clears.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int unsigned WIDTH_X    = DEF_WIDTH_X,
    parameter int unsigned WIDTH_Y    = DEF_WIDTH_Y,
    parameter int unsigned RES_X      = DEF_RES_X,
    parameter int unsigned RES_Y      = DEF_RES_Y,
    parameter int unsigned COLOR_W    = DEF_COLOR_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input logic         clk,
    input logic         reset,
    pixel_sink_if.slave io_bus
);

    localparam int unsigned FIFO_W = WIDTH_X + WIDTH_Y + COLOR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RES_X * RES_Y - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e             r_state;
    state_e             w_state_d;
    logic               w_ready;
    logic               w_accept;
    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_W-1:0]  w_head;
    logic [WIDTH_X-1:0] w_head_x;
    logic [WIDTH_Y-1:0] w_head_y;
    logic [COLOR_W-1:0] w_head_color;
    logic [ADDR_W-1:0]  w_head_addr;
    logic               w_wr_done;
    logic               w_enter_clear;
    logic               w_clear_last;

    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [COLOR_W-1:0] r_data;
    logic [ADDR_W-1:0]  r_frame_cnt;
    logic               r_frame_done;
    logic               r_clear_done;
    logic [7:0]         r_clip_count;

    assign w_accept   = io_bus.plot && w_ready;
    assign w_in_range = (32'(io_bus.x) < RES_X) && (32'(io_bus.y) < RES_Y);
    assign w_push     = w_accept && w_in_range;
    assign w_wr_done  = r_we && io_bus.mem_ready;
    // Refill the output stage when it is idle or its current write retires this edge.
    assign w_pop      = (r_state != StClear) && !w_empty && (!r_we || io_bus.mem_ready);

    assign w_enter_clear = (r_state == StDrain) && (w_state_d == StClear);
    assign w_clear_last  = (r_state == StClear) && w_wr_done && (r_addr == LAST_ADDR);

    pixel_fifo #(
        .DATA_W (FIFO_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({io_bus.x, io_bus.y, io_bus.color}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_x, w_head_y, w_head_color} = w_head;
    assign w_head_addr = ADDR_W'(w_head_y) * ADDR_W'(RES_X) + ADDR_W'(w_head_x);

    always_ff @(posedge clk) begin
        if (reset) r_state <= StStream;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StStream: if (io_bus.clear) w_state_d = StDrain;
            StDrain:  if (w_empty && !r_we) w_state_d = StClear;
            StClear:  if (w_clear_last) w_state_d = StStream;
            default:  w_state_d = StStream;
        endcase
    end

    always_comb begin
        w_ready = (r_state == StStream) && !w_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_enter_clear) begin
            r_we   <= 1'b1;
            r_addr <= '0;
            r_data <= COLOR_W'(CLEAR_COLOR);
        end else if (r_state == StClear) begin
            if (w_wr_done) begin
                if (r_addr == LAST_ADDR) r_we <= 1'b0;
                else                     r_addr <= r_addr + ADDR_ONE;
            end
        end else if (w_pop) begin
            r_we   <= 1'b1;
            r_addr <= w_head_addr;
            r_data <= w_head_color;
        end else if (w_wr_done) begin
            r_we <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_clear_done <= 1'b0;
            r_clip_count <= '0;
        end else begin
            if (w_enter_clear) begin
                r_frame_cnt <= '0;
            end else if (w_wr_done && (r_state != StClear)) begin
                r_frame_cnt <= (r_frame_cnt == LAST_ADDR) ? '0 : r_frame_cnt + ADDR_ONE;
            end
            r_frame_done <= w_wr_done && (r_state != StClear) && (r_frame_cnt == LAST_ADDR);
            r_clear_done <= w_clear_last;
            if (w_accept && !w_in_range && (r_clip_count != 8'hFF)) begin
                r_clip_count <= r_clip_count + 8'd1;
            end
        end
    end

    assign io_bus.ready      = w_ready;
    assign io_bus.mem_we     = r_we;
    assign io_bus.mem_addr   = r_addr;
    assign io_bus.mem_data   = r_data;
    assign io_bus.frame_done = r_frame_done;
    assign io_bus.clear_done = r_clear_done;
    assign io_bus.clip_count = r_clip_count;

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: directed scenarios plus a randomized stream
// compared against a queue-based model of accepted pixels.
module tb_pixel_sink;

    localparam int RX = 10;
    localparam int RY = 6;

    typedef struct {
        logic [5:0] addr;
        logic [2:0] data;
    } px_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pixel_sink_if bus ();

    pixel_sink dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    px_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_clip = 0;

    logic       s_rdy, s_we, s_fd, s_cd;
    logic [5:0] s_addr;
    logic [2:0] s_data;
    logic [7:0] s_clip;
    bit         s_acc, s_wr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Drive one cycle of inputs (called at a negedge), sample pre-edge outputs, update model.
    task automatic step(input bit p, input int sx, input int sy, input int sc,
                        input bit clr, input bit mr);
        bus.plot = p;
        bus.x = 4'(sx);
        bus.y = 3'(sy);
        bus.color = 3'(sc);
        bus.clear = clr;
        bus.mem_ready = mr;
        #1;
        s_rdy = bus.ready;
        s_we = bus.mem_we;
        s_addr = bus.mem_addr;
        s_data = bus.mem_data;
        s_fd = bus.frame_done;
        s_cd = bus.clear_done;
        s_clip = bus.clip_count;
        s_acc = p && (bus.ready === 1'b1) && !reset;
        s_wr = (bus.mem_we === 1'b1) && mr && !reset;
        if (s_acc) begin
            if (sx < RX && sy < RY) exp_q.push_back('{addr: 6'(sy * RX + sx), data: 3'(sc)});
            else if (exp_clip < 255) exp_clip++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        exp_q.delete();
        exp_clip = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step(1, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), 1, 1);
        reset = 1'b0;
        exp_q.delete();
        exp_clip = 0;
        step(0, 0, 0, 0, 0, 1);
        checks += 5;
        if (s_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", s_we); end
        if (s_fd !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b, required 0", s_fd); end
        if (s_cd !== 1'b0) begin errors++; $display("FAIL reset_cd: got %b, required 0", s_cd); end
        if (s_clip !== 8'd0) begin errors++; $display("FAIL reset_clip: got %0d, required 0", s_clip); end
        if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", s_rdy); end
    endtask

    task automatic test_single();
        step(1, 3, 2, 5, 0, 1);
        checks++;
        if (!s_acc) begin errors++; $display("FAIL single_accept: got 0, required 1"); end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (s_we !== 1'b0) begin errors++; $display("FAIL single_early_we: got %b, required 0", s_we); end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (s_we !== 1'b1 || s_addr !== 6'd23 || s_data !== 3'd5) begin
            errors++;
            $display("FAIL single_write: got we=%b addr=%0d data=%0d, required we=1 addr=23 data=5",
                     s_we, s_addr, s_data);
        end
        if (s_wr && exp_q.size() > 0) void'(exp_q.pop_front());
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (s_we !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b, required 0", s_we); end
    endtask

    task automatic test_stall();
        int px_x[8], px_y[8], px_c[8];
        int k = 0, nwr = 0;
        px_t e;
        for (int i = 0; i < 8; i++) begin
            px_x[i] = $urandom_range(0, RX - 1);
            px_y[i] = $urandom_range(0, RY - 1);
            px_c[i] = $urandom_range(0, 7);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, px_x[k], px_y[k], px_c[k], 0, 0);
            if (s_acc) k++;
            if (i >= 2) begin
                checks++;
                if (s_we !== 1'b1 || exp_q.size() == 0 || s_addr !== exp_q[0].addr ||
                    s_data !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL stall_hold: got we=%b addr=%0d data=%0d, required held first pixel",
                             s_we, s_addr, s_data);
                end
            end
        end
        step(0, 0, 0, 0, 0, 0);
        checks += 2;
        if (k != 5) begin errors++; $display("FAIL stall_accepted: got %0d, required 5", k); end
        if (s_rdy !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b, required 0", s_rdy); end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (s_wr) begin
                nwr++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_write: got unexpected addr=%0d, required none", s_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (s_addr !== e.addr || s_data !== e.data) begin
                        errors++;
                        $display("FAIL stall_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 s_addr, s_data, e.addr, e.data);
                    end
                end
            end
        end
        checks++;
        if (nwr != 5) begin errors++; $display("FAIL stall_count: got %0d, required 5", nwr); end
    endtask

    task automatic test_clip();
        do_reset();
        step(1, 10, 0, 1, 0, 1);
        checks++;
        if (!s_acc) begin errors++; $display("FAIL clip_accept_x: got 0, required 1"); end
        step(1, 0, 6, 2, 0, 1);
        checks++;
        if (!s_acc) begin errors++; $display("FAIL clip_accept_y: got 0, required 1"); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            checks++;
            if (s_we !== 1'b0 || s_rdy !== 1'b1) begin
                errors++;
                $display("FAIL clip_idle: got we=%b ready=%b, required we=0 ready=1", s_we, s_rdy);
            end
        end
        checks++;
        if (s_clip !== 8'(exp_clip) || exp_clip != 2) begin
            errors++;
            $display("FAIL clip_count: got %0d, required 2", s_clip);
        end
    endtask

    task automatic test_frame();
        int sent = 0, nwr = 0, fd_cnt = 0, fd_cyc = -1, cyc60 = -1;
        px_t e;
        do_reset();
        for (int cyc = 0; cyc < 100; cyc++) begin
            step(sent < 60, $urandom_range(0, RX - 1), $urandom_range(0, RY - 1),
                 $urandom_range(0, 7), 0, 1);
            if (s_acc) sent++;
            if (s_fd === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
            if (s_wr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_write: got unexpected addr=%0d, required none", s_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (s_addr !== e.addr || s_data !== e.data) begin
                        errors++;
                        $display("FAIL frame_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 s_addr, s_data, e.addr, e.data);
                    end
                end
                nwr++;
                if (nwr == 60) cyc60 = cyc;
            end
        end
        checks += 3;
        if (nwr != 60) begin errors++; $display("FAIL frame_writes: got %0d, required 60", nwr); end
        if (fd_cnt != 1) begin errors++; $display("FAIL frame_pulses: got %0d, required 1", fd_cnt); end
        if (fd_cyc != cyc60 + 1) begin
            errors++;
            $display("FAIL frame_timing: got cycle %0d, required %0d", fd_cyc, cyc60 + 1);
        end
    endtask

    task automatic test_clear();
        int cw = 0, pw = 0, cd_cnt = 0, cd_cyc = -1, cyc_last = -1, fd_cnt = 0, nwr = 0;
        px_t e;
        do_reset();
        step(1, 7, 1, 3, 0, 0);
        step(1, 2, 4, 6, 0, 0);
        checks++;
        if (exp_q.size() != 2) begin errors++; $display("FAIL clear_pending: got %0d, required 2", exp_q.size()); end
        step(0, 0, 0, 0, 1, 0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            step(0, 0, 0, 0, (cw < 60) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 3) != 0);
            if (s_cd === 1'b1) begin cd_cnt++; if (cd_cnt == 1) cd_cyc = cyc; end
            if (s_fd === 1'b1) fd_cnt++;
            if (cd_cnt == 0) begin
                checks++;
                if (s_rdy !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b, required 0", s_rdy); end
            end
            if (s_wr) begin
                checks++;
                if (pw < 2) begin
                    e = exp_q.pop_front();
                    if (s_addr !== e.addr || s_data !== e.data) begin
                        errors++;
                        $display("FAIL clear_pixel: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 s_addr, s_data, e.addr, e.data);
                    end
                    pw++;
                end else begin
                    if (cw >= 60 || s_addr !== 6'(cw) || s_data !== 3'd0) begin
                        errors++;
                        $display("FAIL clear_write: got addr=%0d data=%0d, required addr=%0d data=0",
                                 s_addr, s_data, cw);
                    end
                    cw++;
                    if (cw == 60) cyc_last = cyc;
                end
            end
            if (cd_cnt > 0 && cyc > cd_cyc + 4) break;
        end
        checks += 4;
        if (cw != 60) begin errors++; $display("FAIL clear_count: got %0d, required 60", cw); end
        if (cd_cnt != 1) begin errors++; $display("FAIL clear_done_pulses: got %0d, required 1", cd_cnt); end
        if (cd_cyc != cyc_last + 1) begin
            errors++;
            $display("FAIL clear_done_timing: got cycle %0d, required %0d", cd_cyc, cyc_last + 1);
        end
        if (fd_cnt != 0) begin errors++; $display("FAIL clear_frame_done: got %0d, required 0", fd_cnt); end
        step(1, 4, 3, 6, 0, 1);
        checks++;
        if (s_rdy !== 1'b1) begin errors++; $display("FAIL clear_stream: got ready=%b, required 1", s_rdy); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (s_wr) begin
                nwr++;
                checks++;
                e = exp_q.pop_front();
                if (s_addr !== e.addr || s_data !== e.data) begin
                    errors++;
                    $display("FAIL clear_after: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             s_addr, s_data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (nwr != 1) begin errors++; $display("FAIL clear_after_count: got %0d, required 1", nwr); end
    endtask

    task automatic test_reset_mid_clear();
        bit found = 1'b0;
        int stray = 0;
        do_reset();
        step(1, 12, 1, 3, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 200; i++) begin
            if (bus.mem_we === 1'b1 && bus.mem_addr === 6'd20) begin found = 1'b1; break; end
            step(0, 0, 0, 0, 0, 1);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midclr_reach: got no write to 20, required one"); end
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        exp_q.delete();
        exp_clip = 0;
        step(0, 0, 0, 0, 0, 1);
        checks += 3;
        if (s_we !== 1'b0) begin errors++; $display("FAIL midclr_we: got %b, required 0", s_we); end
        if (s_rdy !== 1'b1) begin errors++; $display("FAIL midclr_ready: got %b, required 1", s_rdy); end
        if (s_clip !== 8'd0) begin errors++; $display("FAIL midclr_clip: got %0d, required 0", s_clip); end
        for (int i = 0; i < 70; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (s_we !== 1'b0 || s_cd !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midclr_stray: got %0d active cycles, required 0", stray); end
    endtask

    task automatic test_random();
        int  wcnt = 0;
        bit  exp_fd = 1'b0;
        px_t e;
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 7),
                     $urandom_range(0, 7), 0, $urandom_range(0, 3) != 0);
            end else begin
                step(0, 0, 0, 0, 0, 1);
            end
            checks++;
            if (s_fd !== exp_fd) begin
                errors++;
                $display("FAIL rand_frame_done: cycle %0d got %b, required %b", cyc, s_fd, exp_fd);
            end
            if (s_wr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_write: got unexpected addr=%0d, required none", s_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (s_addr !== e.addr || s_data !== e.data) begin
                        errors++;
                        $display("FAIL rand_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 s_addr, s_data, e.addr, e.data);
                    end
                end
                wcnt++;
                exp_fd = (wcnt % (RX * RY) == 0);
            end else begin
                exp_fd = 1'b0;
            end
        end
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d left, required 0", exp_q.size()); end
        if (s_clip !== 8'(exp_clip)) begin
            errors++;
            $display("FAIL rand_clip: got %0d, required %0d", s_clip, exp_clip);
        end
    endtask

    initial begin
        bus.plot = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.color = '0;
        bus.clear = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_clip();
        test_frame();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter WIDTH_X, default 4, x coordinate width.
REQ-002 Parameter WIDTH_Y, default 3, y coordinate width.
REQ-003 Parameter RES_X, default 10, screen width in pixels.
REQ-004 Parameter RES_Y, default 6, screen height in pixels.
REQ-005 Parameter COLOR_W, default 3, color width.
REQ-006 Parameter FIFO_DEPTH, default 4, number of input buffer entries (power of two).
REQ-007 Parameter ADDR_W, default 6, framebuffer address width, which SHALL be at least clog2(RES_X*RES_Y).
REQ-008 clk  in  1  clock; all state changes on the rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 plot  in  1  pixel write request from the plotter/FSM side.
REQ-011 x  in  WIDTH_X  pixel column.
REQ-012 y  in  WIDTH_Y  pixel row.
REQ-013 color  in  COLOR_W  pixel color.
REQ-014 ready  out  1  sink can accept a pixel this cycle.
REQ-015 clear  in  1  request a full-screen clear to color 0.
REQ-016 mem_we  out  1  framebuffer write strobe.
REQ-017 mem_addr  out  ADDR_W  framebuffer address.
REQ-018 mem_data  out  COLOR_W  framebuffer write data.
REQ-019 mem_ready  in  1  framebuffer accepts the write this cycle.
REQ-020 frame_done  out  1  one-cycle pulse when a full frame of writes completes.
REQ-021 clear_done  out  1  one-cycle pulse when a clear completes.
REQ-022 clip_count  out  8  count of discarded out-of-range pixels, saturating at 255.

Function
REQ-023 A pixel SHALL be accepted on a rising edge where plot=1 and ready=1.
REQ-024 ready SHALL be 1 only in state STREAM with the FIFO not full; a same-cycle pop does not raise ready.
REQ-025 An accepted pixel with x>=RES_X or y>=RES_Y SHALL be discarded (not enqueued) and SHALL increment clip_count.
REQ-026 An accepted in-range pixel SHALL be enqueued in FIFO order.
REQ-027 The output stage (mem_we, mem_addr, mem_data) SHALL be registered.
REQ-028 The FIFO head SHALL load into the output stage when the stage is empty or when mem_we=1 and mem_ready=1 on the same edge.
REQ-029 Minimum latency: a pixel accepted into an empty FIFO with an idle output stage at edge N SHALL have mem_we=1 from edge N+1.
REQ-030 mem_addr SHALL equal y*RES_X+x, computed at ADDR_W width; mem_data SHALL equal color.
REQ-031 While mem_we=1 and mem_ready=0, mem_we, mem_addr and mem_data SHALL hold stable.
REQ-032 A completed write is an edge with mem_we=1 and mem_ready=1; completed STREAM writes SHALL be counted modulo RES_X*RES_Y.
REQ-033 frame_done SHALL pulse for one cycle after the completed write that wraps this counter to 0.
REQ-034 The state machine SHALL have states STREAM, DRAIN and CLEAR.
REQ-035 STREAM->DRAIN: on clear=1; the request is latched, so clear may then deassert.
REQ-036 DRAIN: ready=0; remaining FIFO and output-stage pixels SHALL be written.
REQ-037 DRAIN->CLEAR: when the FIFO is empty and the output stage is idle.
REQ-038 CLEAR: ready=0; the block SHALL write addresses 0..RES_X*RES_Y-1 in order with data 0, honoring mem_ready.
REQ-039 CLEAR writes SHALL NOT advance the frame counter; entering CLEAR SHALL zero that counter.
REQ-040 CLEAR->STREAM: after the last completed clear write; clear_done SHALL pulse for one cycle on the following cycle.
REQ-041 clear asserted during DRAIN or CLEAR SHALL be ignored.

Reset
REQ-042 On reset the block SHALL enter STREAM with the FIFO empty, the output stage idle, and all counters zero.
REQ-043 On reset mem_we, frame_done and clear_done SHALL be 0, ready SHALL be 1 from the next cycle, and clip_count SHALL be 0.
REQ-044 Reset in any state, including mid-CLEAR, SHALL abort the operation, discard pending pixels, and leave no further mem_we.

Structure
REQ-045 A shared package SHALL hold the default resolution and color constants and the state encoding (STREAM=0, DRAIN=1, CLEAR=2).
REQ-046 The FIFO SHALL be a sub-module named pixel_fifo with push, pop, full, empty and a data word {x, y, color}.

Verification
REQ-047 The bench SHALL drive plot x=3 y=2 color=5 with mem_ready=1 and check mem_we=1, mem_addr=23, mem_data=5 exactly one cycle after acceptance, for exactly one cycle.
REQ-048 The bench SHALL hold mem_ready=0 and offer 8 pixels, then raise mem_ready, and check:
- exactly 5 pixels are accepted (4 in FIFO, 1 in output stage) and ready=0;
- outputs hold stable while stalled;
- the 5 writes complete in order.
REQ-049 The bench SHALL send x=10 y=0 and x=0 y=6 and check no mem_we, clip_count=2, and ready stays 1.
REQ-050 The bench SHALL send 60 in-range pixels with mem_ready=1 and check frame_done pulses once, on the cycle after the 60th completed write.
REQ-051 The bench SHALL pulse clear with 2 pixels pending and check:
- both pixels are written first;
- then 60 writes to addresses 0..59 with data 0;
- ready=0 throughout;
- clear_done pulses once;
- the block returns to STREAM.
REQ-052 The bench SHALL assert reset during CLEAR at address 20 and check mem_we=0 from the next cycle, ready=1 after reset, and clip_count=0.
